// File: rtl/ising_axi.sv
// ising_axi: register-mapped sequential Ising solver behind a simple AXI-lite-style slave.
// Optional feature: define ISING_AXI_SWEEPCNT_EN to expose the completed-sweep count
// as a read-only register at 0x0000_000C (otherwise that address is unmapped).
`timescale 1ns/1ps

`define START_ADDR       32'h0000_0000
`define CTR_CUTOFF_ADDR  32'h0000_0004
`define CTR_MAX_ADDR     32'h0000_0008
`define PHASE_ADDR_BASE  32'h0001_0000
`define WEIGHT_ADDR_BASE 32'h0010_0000

module ising_axi #(
  parameter int N           = 8,
  parameter int WIRE_DELAY  = 20,
  parameter int NUM_WEIGHTS = 5
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        arvalid_q,
  input  logic [31:0] araddr_q,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  input  logic        wready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wdata
);

  localparam int W   = $clog2(NUM_WEIGHTS);
  localparam int MID = (NUM_WEIGHTS - 1) / 2;
  localparam int IW  = $clog2(N);
  localparam int HW  = $clog2(N * MID + 1) + 2;

  localparam logic [W-1:0]  MID_CODE = W'(MID);
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [31:0]   WBASE    = `WEIGHT_ADDR_BASE;
  localparam logic [31:0]   PBASE    = `PHASE_ADDR_BASE;

  // WIRE_DELAY only matters for the oscillator-array variant; it is range-checked here
  if (N < 2 || N > 64 || NUM_WEIGHTS < 3 || (NUM_WEIGHTS % 2) == 0 || WIRE_DELAY < 0) begin : g_param_check
    $error("ising_axi: unsupported parameter set");
  end

  // Weight entry: row in bits [19:13], column in bits [12:2], both below N
  function automatic logic is_weight(input logic [31:0] a);
    return (a[31:20] == WBASE[31:20]) && (a[1:0] == 2'b00) &&
           (a[19:13] < 7'(N)) && (a[12:2] < 11'(N));
  endfunction

  function automatic logic is_phase(input logic [31:0] a);
    return (a[31:16] == PBASE[31:16]) && (a[1:0] == 2'b00) && (a[15:2] < 14'(N));
  endfunction

  logic [W-1:0]          weights [N][N];
  logic [15:0]           ctr_cutoff;
  logic [15:0]           ctr_max;
  logic [N-1:0]          spin;
  logic [N-1:0]          spin_init;
  logic [N-1:0]          spin_next;
  logic [15:0]           phase [N];
  logic [IW-1:0]         idx;
  logic                  busy;
  logic [31:0]           remaining;
  logic [31:0]           sweeps_done;
  logic signed [HW-1:0]  field;
  logic signed [HW-1:0]  wv;
  logic [31:0]           rd_data;
  logic                  rd_err;
  logic                  start_wr;

  assign start_wr = wready && (wr_addr == `START_ADDR);

  // Configuration writes: coupling matrix and counter limits, accepted at any time
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          weights[r][c] <= MID_CODE;
      ctr_cutoff <= 16'h0000;
      ctr_max    <= 16'h00FF;
    end else if (wready) begin
      if (wr_addr == `CTR_CUTOFF_ADDR) ctr_cutoff <= wdata[15:0];
      if (wr_addr == `CTR_MAX_ADDR)    ctr_max    <= wdata[15:0];
      if (is_weight(wr_addr))
        weights[wr_addr[13 +: IW]][wr_addr[2 +: IW]] <= wdata[W-1:0];
    end
  end

  // Initial spins come from the diagonal codes: below mid is -1 (0), otherwise +1 (1)
  always_comb begin
    spin_init = '0;
    for (int i = 0; i < N; i++)
      spin_init[i] = (weights[i][i] >= MID_CODE);
  end

  // Local field on spin idx, skipping the diagonal, then the sign decides the new spin
  always_comb begin
    field     = '0;
    wv        = '0;
    spin_next = spin;
    for (int j = 0; j < N; j++) begin
      wv = HW'(weights[idx][j]) - HW'(MID);
      if (IW'(j) != idx)
        field = spin[j] ? (field + wv) : (field - wv);
    end
    if (field[HW-1])
      spin_next[idx] = 1'b0;
    else if (field != '0)
      spin_next[idx] = 1'b1;
  end

  // Anneal engine: START reloads everything; each busy cycle updates one spin and
  // the last spin of a sweep also closes the sweep and updates the phase counters
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      spin        <= '1;
      idx         <= '0;
      busy        <= 1'b0;
      remaining   <= '0;
      sweeps_done <= '0;
      for (int i = 0; i < N; i++) phase[i] <= '0;
    end else if (start_wr) begin
      spin        <= spin_init;
      idx         <= '0;
      busy        <= (wdata != 32'd0);
      remaining   <= wdata;
      sweeps_done <= '0;
      for (int i = 0; i < N; i++) phase[i] <= '0;
    end else if (busy) begin
      spin <= spin_next;
      if (idx == LAST) begin
        idx         <= '0;
        sweeps_done <= sweeps_done + 32'd1;
        remaining   <= remaining - 32'd1;
        if (remaining == 32'd1) busy <= 1'b0;
        if (sweeps_done >= {16'h0000, ctr_cutoff}) begin
          for (int i = 0; i < N; i++) begin
            if (spin_next[i] == spin_next[N-1]) begin
              if (phase[i] < ctr_max) phase[i] <= phase[i] + 16'd1;
            end else if (phase[i] != 16'd0) begin
              phase[i] <= phase[i] - 16'd1;
            end
          end
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Read address decode; phase readback is index-reversed relative to spin N-1
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (araddr_q == `START_ADDR)
      rd_data = {busy, 15'b0, remaining[15:0]};
    else if (araddr_q == `CTR_CUTOFF_ADDR)
      rd_data = {16'h0000, ctr_cutoff};
    else if (araddr_q == `CTR_MAX_ADDR)
      rd_data = {16'h0000, ctr_max};
`ifdef ISING_AXI_SWEEPCNT_EN
    else if (araddr_q == 32'h0000_000C)
      rd_data = sweeps_done;
`endif
    else if (is_weight(araddr_q))
      rd_data = 32'(weights[araddr_q[13 +: IW]][araddr_q[2 +: IW]]);
    else if (is_phase(araddr_q))
      rd_data = 32'(phase[LAST - araddr_q[2 +: IW]]);
    else
      rd_err = 1'b1;
  end

  // Read channel: one-cycle latency, data held until the master accepts it
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rvalid <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
    end else if (arvalid_q) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ising_axi.sv
// tb_ising_axi: directed scoreboard bench for ising_axi (N = 8, 5 weight levels).
// Define ISING_AXI_SWEEPCNT_EN for both files to exercise the sweep-count register.
`timescale 1ns/1ps

module tb_ising_axi;

  localparam logic [31:0] START_A  = 32'h0000_0000;
  localparam logic [31:0] CUTOFF_A = 32'h0000_0004;
  localparam logic [31:0] MAX_A    = 32'h0000_0008;
  localparam logic [31:0] SWEEP_A  = 32'h0000_000C;
  localparam logic [31:0] PBASE    = 32'h0001_0000;
  localparam logic [31:0] WBASE    = 32'h0010_0000;

  logic        clk;
  logic        axi_rstn;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expQ[$];
  logic [1:0]  respQ[$];
  string       tagQ[$];

  ising_axi #(.N(8), .WIRE_DELAY(20), .NUM_WEIGHTS(5)) dut (
    .clk(clk), .axi_rstn(axi_rstn),
    .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
    .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] waddr(input int r, input int c);
    return WBASE + 32'(c << 2) + 32'(r << 13);
  endfunction

  function automatic logic [31:0] paddr(input int k);
    return PBASE + 32'(k << 2);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    wready  = 1'b1;
    wr_addr = a;
    wdata   = d;
    @(negedge clk);
    wready  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput();
    logic [31:0] e;
    logic [1:0]  er;
    string       t;
    if (expQ.size() == 0) return;
    e  = expQ.pop_front();
    er = respQ.pop_front();
    t  = tagQ.pop_front();
    checkVal({t, "_rvalid"}, 32'(rvalid), 32'd1);
    checkVal({t, "_rdata"}, rdata, e);
    checkVal({t, "_rresp"}, 32'(rresp), 32'(er));
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] exp,
                               input logic [1:0] resp, input string tag);
    arvalid_q = 1'b1;
    araddr_q  = a;
    expQ.push_back(exp);
    respQ.push_back(resp);
    tagQ.push_back(tag);
    @(negedge clk);
    arvalid_q = 1'b0;
    checkOutput();
  endtask

  int ea[6] = '{0, 0, 1, 1, 2, 3};
  int eb[6] = '{1, 4, 2, 3, 3, 4};

  // Directed sequence of register programming, runs and readbacks
  initial begin
    axi_rstn = 1'b0; arvalid_q = 1'b0; araddr_q = '0; rready = 1'b1;
    wready = 1'b0; wr_addr = '0; wdata = '0;
    idle(3);
    checkVal("reset_rvalid", 32'(rvalid), 32'd0);
    checkVal("reset_rdata", rdata, 32'd0);
    checkVal("reset_rresp", 32'(rresp), 32'd0);
    axi_rstn = 1'b1;

    applyStimulus(waddr(1, 0), 32'h2, 2'b00, "w10_reset");
    applyStimulus(MAX_A, 32'h00FF, 2'b00, "max_reset");
    applyStimulus(CUTOFF_A, 32'h0, 2'b00, "cutoff_reset");
    applyStimulus(START_A, 32'h0, 2'b00, "start_reset");
    applyStimulus(waddr(0, 8), 32'h0, 2'b10, "unmapped_col");
`ifdef ISING_AXI_SWEEPCNT_EN
    applyStimulus(SWEEP_A, 32'h0, 2'b00, "sweepcnt_reset");
`else
    applyStimulus(SWEEP_A, 32'h0, 2'b10, "sweepcnt_unmapped");
`endif

    rready = 1'b0;
    applyStimulus(MAX_A, 32'h00FF, 2'b00, "hold_read");
    idle(1);
    checkVal("hold_rvalid", 32'(rvalid), 32'd1);
    checkVal("hold_rdata", rdata, 32'h00FF);
    rready = 1'b1;
    idle(1);
    checkVal("clear_rvalid", 32'(rvalid), 32'd0);

    writeReg(waddr(0, 1), 32'h0);
    applyStimulus(waddr(0, 1), 32'h0, 2'b00, "w01_write");
    wready = 1'b0; wr_addr = waddr(0, 0); wdata = 32'h0;
    idle(1);
    applyStimulus(waddr(0, 0), 32'h2, 2'b00, "w00_nowrite");
    writeReg(waddr(0, 1), 32'h2);

    $display("[TB] two-spin antiferromagnet");
    writeReg(waddr(0, 7), 32'h0);
    writeReg(waddr(7, 0), 32'h0);
    writeReg(CUTOFF_A, 32'd4);
    writeReg(MAX_A, 32'd8);
    writeReg(START_A, 32'd16);
    applyStimulus(START_A, 32'h8000_0010, 2'b00, "af_busy");
    idle(140);
    applyStimulus(START_A, 32'h0, 2'b00, "af_done");
    applyStimulus(paddr(7), 32'd0, 2'b00, "af_spin0");
    applyStimulus(paddr(0), 32'd8, 2'b00, "af_spin7");
    applyStimulus(paddr(3), 32'd8, 2'b00, "af_spin4");
`ifdef ISING_AXI_SWEEPCNT_EN
    applyStimulus(SWEEP_A, 32'd16, 2'b00, "af_sweepcnt");
`endif

    writeReg(MAX_A, 32'h00FF);
    writeReg(START_A, 32'd16);
    idle(140);
    applyStimulus(paddr(0), 32'd12, 2'b00, "af_cut_spin7");
    applyStimulus(paddr(1), 32'd12, 2'b00, "af_cut_spin6");
    applyStimulus(paddr(7), 32'd0, 2'b00, "af_cut_spin0");

    $display("[TB] stop mid-run");
    writeReg(START_A, 32'd16);
    idle(40);
    writeReg(START_A, 32'd0);
    applyStimulus(START_A, 32'h0, 2'b00, "stop_busy");
    applyStimulus(paddr(0), 32'd0, 2'b00, "stop_spin7_a");
    idle(50);
    applyStimulus(paddr(0), 32'd0, 2'b00, "stop_spin7_b");
    applyStimulus(START_A, 32'h0, 2'b00, "stop_still_idle");

`ifdef ISING_AXI_SWEEPCNT_EN
    writeReg(START_A, 32'd5);
    idle(5 * 8 + 2);
    applyStimulus(SWEEP_A, 32'd5, 2'b00, "sweepcnt_5");
`endif

    $display("[TB] max-cut");
    writeReg(MAX_A, 32'd8);
    for (int e = 0; e < 6; e++) begin
      writeReg(waddr(ea[e], eb[e]), 32'h0);
      writeReg(waddr(eb[e], ea[e]), 32'h0);
    end
    writeReg(waddr(0, 7), 32'h4);
    writeReg(waddr(7, 0), 32'h4);
    writeReg(START_A, 32'd16);
    idle(40);
    writeReg(START_A, 32'd256);
    idle(2070);
    applyStimulus(START_A, 32'h0, 2'b00, "mc_done");
    applyStimulus(paddr(7), 32'd8, 2'b00, "mc_A");
    applyStimulus(paddr(4), 32'd8, 2'b00, "mc_D");
    applyStimulus(paddr(0), 32'd8, 2'b00, "mc_H");
    applyStimulus(paddr(6), 32'd0, 2'b00, "mc_B");
    applyStimulus(paddr(5), 32'd0, 2'b00, "mc_C");
    applyStimulus(paddr(3), 32'd0, 2'b00, "mc_E");
`ifdef ISING_AXI_SWEEPCNT_EN
    applyStimulus(SWEEP_A, 32'd256, 2'b00, "mc_sweepcnt");
`endif

    // Read and write of the same register on one edge returns the old value
    wready = 1'b1; wr_addr = CUTOFF_A; wdata = 32'd9;
    arvalid_q = 1'b1; araddr_q = CUTOFF_A;
    expQ.push_back(32'd4); respQ.push_back(2'b00); tagQ.push_back("rw_same_old");
    @(negedge clk);
    wready = 1'b0; arvalid_q = 1'b0;
    checkOutput();
    applyStimulus(CUTOFF_A, 32'd9, 2'b00, "rw_same_new");

    $display("[TB] async reset mid-run");
    writeReg(CUTOFF_A, 32'd4);
    writeReg(START_A, 32'd16);
    idle(20);
    rready = 1'b0;
    applyStimulus(START_A, 32'h8000_000E, 2'b00, "ar_remaining");
    #2 axi_rstn = 1'b0;
    #1;
    checkVal("ar_rvalid_async", 32'(rvalid), 32'd0);
    checkVal("ar_rdata_async", rdata, 32'd0);
    @(negedge clk);
    axi_rstn = 1'b1;
    rready = 1'b1;
    applyStimulus(START_A, 32'h0, 2'b00, "ar_start");
    applyStimulus(waddr(0, 1), 32'h2, 2'b00, "ar_w01");
    applyStimulus(MAX_A, 32'h00FF, 2'b00, "ar_max");
    applyStimulus(paddr(0), 32'd0, 2'b00, "ar_phase");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ising_axi.md
# ising_axi

Register-mapped digital Ising-model solver with N fully connected spins. It sits behind a simplified AXI-lite-style slave port on the accelerator fabric. Software programs a signed N×N coupling matrix, burn-in and saturation limits, then writes a sweep count to start a deterministic sequential anneal. Per-spin phase counters are read back, referenced to spin N-1, which acts as the local-field spin.

## Interface
- N, 8: number of spins; 2..64.
- WIRE_DELAY, 20: kept for compatibility with the oscillator-array variant; no functional effect.
- NUM_WEIGHTS, 5: odd number of weight levels.
  - Code width W = $clog2(NUM_WEIGHTS).
  - Code c encodes weight c − (NUM_WEIGHTS−1)/2; with the default 5 levels, codes 0..4 map to −2..+2.
- clk, input, 1: single clock, rising edge.
- axi_rstn, input, 1: reset, asynchronous and active-low.
- arvalid_q, input, 1: read request this cycle.
- araddr_q, input, 32: read address.
- rready, input, 1: master accepts read data.
- rvalid, output, 1: read data valid.
- rresp, output, 2: 00 OKAY, 10 SLVERR for an unmapped address.
- rdata, output, 32: read data.
- wready, input, 1: write strobe; a write is performed on every rising edge where it is high.
- wr_addr, input, 32: write address.
- wdata, input, 32: write data.

## Operation
- Address map (header macros):
  - START_ADDR 0x0000_0000
  - CTR_CUTOFF_ADDR 0x0000_0004
  - CTR_MAX_ADDR 0x0000_0008
  - PHASE_ADDR_BASE 0x0001_0000
  - WEIGHT_ADDR_BASE 0x0010_0000
- Weight entry (row r, col c) address: WEIGHT_ADDR_BASE + (c<<2) + (r<<13); data is wdata[W-1:0].
  - Reset value of every entry: mid code (NUM_WEIGHTS−1)/2, i.e. weight 0.
  - Off-diagonal entry w[r][c] is the coupling from spin c into spin r. The matrix is not forced symmetric.
  - Diagonal entry w[i][i] is the initial spin: code < mid → −1, otherwise +1. It is excluded from the field sum.
- CTR_CUTOFF (16 bits): number of initial burn-in sweeps per run; reset value 0.
- CTR_MAX (16 bits): phase-counter saturation value; reset value 0x00FF.
- START write with wdata = S:
  - Loads all spins from the diagonal.
  - Clears all phase counters and the sweep/index counters.
  - Sets busy if S ≠ 0; S = 0 stops the run.
  - A START write during a run restarts it.
- Update rule, while busy: each cycle, spin idx computes h = Σ_{j≠idx} weight(w[idx][j])·s_j using signed arithmetic wide enough for N·max|weight|.
  - h > 0 → s = +1.
  - h < 0 → s = −1.
  - h = 0 → s is unchanged.
  - idx runs 0..N−1; one sweep takes N cycles.
- End of each sweep k (1-based), if k > CTR_CUTOFF, every counter i is updated using the post-sweep spins:
  - s_i == s_{N−1} → increment, saturating at CTR_MAX.
  - otherwise → decrement, saturating at 0.
- After S sweeps, busy clears; spins and counters freeze.
- Phase readback: PHASE_ADDR_BASE + (k<<2) returns counter of spin N−1−k (reversed index), zero-extended to 32 bits.
- Readback of other registers:
  - Weights read back as {zeros, code}.
  - CTR registers read back their value.
  - START reads {busy, 15'b0, remaining sweeps[15:0]}.
- Weight and CTR writes are accepted at any time. A weight write takes effect at the next field evaluation.
- A write to an unmapped address is ignored.

## Timing
- Reset values:
  - rdata = 0, rvalid = 0, rresp = 00.
  - busy = 0; spins = +1; counters = 0.
  - Weights and CTR registers as listed in Operation.
- Read latency is 1 cycle: an edge with arvalid_q high registers rdata, sets rvalid = 1 and sets rresp.
- rvalid clears on an edge with rready high and arvalid_q low. rdata holds its value otherwise.
- START write edge = cycle 0: the spin 0 update lands at edge 1, and the run ends at edge N·S.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Asynchronous reset mid-run aborts the run immediately.

## Configuration
- ISING_AXI_SWEEPCNT_EN defined: read-only register at 0x0000_000C returns the number of completed sweeps of the current or last run, 32 bits, cleared by START.
- ISING_AXI_SWEEPCNT_EN undefined: 0x0000_000C is unmapped and returns 0 with rresp 10.

## Test plan
- After reset, read weight (r=1, c=0) → rdata[2:0] = 3'b010, rvalid high one cycle after request.
- Write code 0 to (0,1), then read it back → 3'b000. Write to (0,0) with wready low → ignored; diagonal still reads 3'b010.
- Two-spin antiferromagnet: w[0][7] = w[7][0] = code 0; CUTOFF = 4, MAX = 8; START = 16. After 128+ cycles:
  - phase at PHASE_ADDR_BASE + (7<<2) (spin 0) = 0.
  - phase at PHASE_ADDR_BASE + 0 (spin 7) = 8.
- Max-cut, all initial spins +1, CUTOFF = 4, MAX = 8:
  - Couplings −2 on edges AB, AE, BC, BD, CD, DE; +2 on A–H (spins A..E = 0..4, H = 7).
  - START = 16, then restart with START = 256 mid-run and wait ≥ 2048 cycles.
  - Phase reads (spin → value): A = 8, D = 8, H = 8; B = 0, C = 0, E = 0.
- START = 0 during a run → busy reads 0 the next cycle; phase counters are frozen.
- With ISING_AXI_SWEEPCNT_EN defined, START = 5 → register 0xC reads 5 after 5·N cycles.
